// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue feeding decode.
// Optional same-cycle empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.

module fetch_queue_entry #(
  parameter int W = 64
) (
  input  logic         CLK,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Storage is don't-care after reset; occupancy lives in the parent's counters.
  always_ff @(posedge CLK)
    if (we) q <= d;
endmodule

module fetch_queue_unit #(
  parameter int                 WORD_W  = 32,
  parameter int                 DEPTH   = 4,
  parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       valid,
  output logic [WORD_W-1:0]          instr,
  output logic [WORD_W-1:0]          pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc4;
  } fq_ent_t;

  typedef enum logic [1:0] {FETCH, FULL, HALTED} st_t;

  st_t                               state, state_nx;
  logic [WORD_W-1:0]                 pc, pc4;
  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     cnt, cnt_nx;
  logic                              empty, push, pop, wr_en, byp_take;
  fq_ent_t                           wr_data, head;
  logic [DEPTH-1:0][2*WORD_W-1:0]    ent_q;

  assign pc4      = pc + WORD_W'(4);
  assign empty    = (cnt == '0);
  assign push     = imemREN & ihit;
  assign pop      = deq & !empty;
  assign wr_en    = push & !byp_take;
  assign wr_data  = '{instr: imemload, pc4: pc4};
  assign imemaddr = pc;
  assign count    = cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    fetch_queue_entry #(.W(2*WORD_W)) u_ent (
      .CLK (CLK),
      .we  (wr_en && (wr_ptr == PW'(i))),
      .d   (wr_data),
      .q   (ent_q[i])
    );
  end

`ifdef FETCHQ_BYPASS_EN
  // Empty queue: the arriving word is the head this cycle; if decode takes it, it never lands.
  logic byp;
  assign byp      = empty & push;
  assign byp_take = byp & deq;
  assign valid    = !empty | byp;
  assign head     = empty ? wr_data : fq_ent_t'(ent_q[rd_ptr]);
`else
  assign byp_take = 1'b0;
  assign valid    = !empty;
  assign head     = fq_ent_t'(ent_q[rd_ptr]);
`endif

  assign instr    = valid ? head.instr : '0;
  assign pc_plus4 = valid ? head.pc4   : '0;

  always_comb begin
    cnt_nx = cnt;
    case ({wr_en, pop})
      2'b10:   cnt_nx = cnt + CW'(1);
      2'b01:   cnt_nx = cnt - CW'(1);
      default: cnt_nx = cnt;
    endcase
  end

  // Redirect wins over push/pop; the halt freeze is tracked by the FSM only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc     <= PC_INIT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc & ~WORD_W'(3);
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)  pc     <= pc4;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_nx;
    end
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) state <= FETCH;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (halt) state_nx = HALTED;
               else if (!redirect && cnt_nx == CW'(DEPTH)) state_nx = FULL;
      FULL:    if (halt) state_nx = HALTED;
               else if (pop || redirect) state_nx = FETCH;
      HALTED:  state_nx = HALTED;
      default: state_nx = FETCH;
    endcase
  end

  // Request only from FETCH; held low while reset is asserted.
  always_comb begin
    imemREN = nRST & (state == FETCH) & !redirect;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the single-entry fetch/decode register with a DEPTH-entry prefetch queue. It owns the PC register and issues instruction-memory requests to the cache interface. It supports redirect and flush from branch, jump and JR resolution, plus a halt freeze, and hands decode a valid/ready stream of {instruction, PC+4}.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
DEPTH, 4, queue entries; power of two, minimum 2.
WORD_W, 32, instruction and PC width.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  instruction memory returned imemload for the current imemaddr this cycle.
imemload  in  WORD_W  fetched instruction.
imemREN  out  1  instruction read request.
imemaddr  out  WORD_W  current fetch PC.
redirect  in  1  flush the queue and restart fetch at redirect_pc.
redirect_pc  in  WORD_W  new fetch target; bits [1:0] are ignored and forced to 0.
halt  in  1  freeze fetch (sticky).
deq  in  1  decode consumes the head entry this cycle.
valid  out  1  head entry present.
instr  out  WORD_W  head instruction (0 when !valid).
pc_plus4  out  WORD_W  head PC+4 (0 when !valid).
count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, nRST low) values: PC=PC_INIT; count=0; wr_ptr=rd_ptr=0; halted=0; imemREN=0 during reset; valid=0; instr=0; pc_plus4=0. Queue storage contents are don't-care.
- imemREN = !full & !halted & !redirect. The signal is combinational from registered state plus redirect.
- imemaddr = PC at all times.
- Push: when imemREN & ihit, write {imemload, PC+4} at wr_ptr, then wr_ptr++ and PC <= PC+4.
- Pop: when deq & valid, rd_ptr++. deq while !valid is ignored.
- count update:
  - push and pop in the same cycle: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full: count==DEPTH. No push when full, even if a pop occurs that cycle, so a full queue refills one cycle after a pop.
- Pointers are log2(DEPTH) bits and wrap naturally. PC arithmetic is modulo 2^WORD_W.
- Default latency: an instruction accepted on ihit at edge N is visible at valid/instr after edge N (next cycle).
- Redirect has priority over all other events:
  - at the next edge, count=0, pointers=0, PC=redirect_pc & ~3;
  - any ihit or deq in the same cycle is discarded;
  - fetch resumes the following cycle.
- Back-to-back redirects: the last one wins.
- Halt: when halt is high at an edge, halted<=1. halted stays set until reset; redirect does not clear it.
  - While halted, imemREN=0 and PC holds.
  - Queue entries still drain via deq.
  - halt and redirect in the same cycle: flush and load PC, then halted.
- ihit while imemREN=0 is ignored.

State machine (fetch control), states FETCH, FULL, HALTED:
- FETCH: request. Go to FULL when a push makes count==DEPTH. Go to HALTED on halt.
- FULL: no request. Go to FETCH on pop or redirect. Go to HALTED on halt.
- HALTED: terminal until nRST.

Optional Feature:
Macro FETCHQ_BYPASS_EN.
- Defined: when the queue is empty (count==0), !redirect and imemREN & ihit, the incoming word is presented combinationally on valid/instr/pc_plus4 in the same cycle.
  - If deq is also high that cycle, the word is consumed and not written; count stays 0 and PC still advances.
  - If deq is low, it is written normally.
- Not defined: strict one-cycle fill latency as above, with no combinational path from imemload or ihit to valid, instr or pc_plus4.

Test Plan:
1. Reset, DEPTH=4, ihit held 1, deq=0, imemload=addr-derived -> imemaddr steps 0,4,8,12; imemREN drops after 4 pushes; count=4; instr=word@0, pc_plus4=4.
2. Full queue, pulse deq one cycle -> count=3, head pc_plus4=8; next cycle imemREN=1; refill fetches addr 16; count=4.
3. Queue holding 2 entries; redirect=1, redirect_pc=32'h0000_0103 with ihit=1 and deq=1 -> next cycle count=0, valid=0, imemaddr=32'h0000_0100; the following cycle imemREN=1.
4. ihit toggling 1,0,1,0 with deq=1 every cycle -> in-order output pc_plus4 4,8,…; count never exceeds 1; no duplicates or loss.
5. halt pulse with count=3 -> imemREN=0 permanently; three deq pulses drain pc_plus4 values in order; then valid=0; a redirect does not resume fetch.
6. FETCHQ_BYPASS_EN defined, empty queue, ihit=1, deq=1 -> valid=1 and instr=imemload in the same cycle; count stays 0; PC advances by 4.
